// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate response checker.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Truth tables for 2-input gates, bit i is the output for input vector i
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/gate_response_checker.sv
// Compares applied gate vectors and outputs against a latched truth table.
// Optional idle watchdog enabled by GATE_CHK_TIMEOUT_EN.
module gate_response_checker
    import gate_chk_pkg::*;
#(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned TO_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   truth_tbl,
    input  logic                 in_valid,
    input  logic [N_IN-1:0]      in_vec,
    input  logic                 dut_y,
    output logic                 busy,
    output logic                 done,
    output logic                 all_pass,
    output logic [CNT_W-1:0]     pass_cnt,
    output logic [CNT_W-1:0]     fail_cnt,
    output logic                 first_fail_vld,
    output logic [N_IN-1:0]      first_fail_vec,
    output logic [2**N_IN-1:0]   cov_map,
    output logic                 timeout
);

    localparam int unsigned N_ENT = 2**N_IN;
    localparam int unsigned TO_W  = $clog2(TO_CYC) + 1;

    state_t             state_q, state_d;
    logic [N_ENT-1:0]   tbl_q;
    logic [N_ENT-1:0]   cov_nxt;
    logic               sample;
    logic               match;
    logic               to_hit;

    // A start cycle never counts as a sample, even with in_valid high
    assign sample  = (state_q == ST_RUN) && in_valid && !start;
    assign match   = (dut_y == tbl_q[in_vec]);
    assign cov_nxt = cov_map | (N_ENT'(1) << in_vec);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (start) begin
                    state_d = ST_RUN;
                end else if (sample && (cov_nxt == {N_ENT{1'b1}})) begin
                    state_d = ST_DONE;
                end else if (to_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign all_pass = done && (fail_cnt == '0) && !timeout;

    // Table latch, coverage and first-failure capture
    always_ff @(posedge clk) begin
        if (rst) begin
            tbl_q          <= '0;
            cov_map        <= '0;
            first_fail_vld <= 1'b0;
            first_fail_vec <= '0;
        end else if (start) begin
            tbl_q          <= truth_tbl;
            cov_map        <= '0;
            first_fail_vld <= 1'b0;
            first_fail_vec <= '0;
        end else if (sample) begin
            cov_map <= cov_nxt;
            if (!match && !first_fail_vld) begin
                first_fail_vld <= 1'b1;
                first_fail_vec <= in_vec;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_pass (
        .clk (clk),
        .rst (rst),
        .clr (start),
        .inc (sample && match),
        .q   (pass_cnt)
    );

    sat_counter #(.W(CNT_W)) u_fail (
        .clk (clk),
        .rst (rst),
        .clr (start),
        .inc (sample && !match),
        .q   (fail_cnt)
    );

`ifdef GATE_CHK_TIMEOUT_EN
    logic [TO_W-1:0] idle_cnt;
    logic            timeout_q;

    // Counts RUN cycles since the last sample or start
    sat_counter #(.W(TO_W)) u_idle (
        .clk (clk),
        .rst (rst),
        .clr ((state_q != ST_RUN) || in_valid || start),
        .inc (1'b1),
        .q   (idle_cnt)
    );

    assign to_hit = (state_q == ST_RUN) && !in_valid && !start &&
                    (idle_cnt == TO_W'(TO_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else if (start) begin
            timeout_q <= 1'b0;
        end else if (to_hit) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout = timeout_q;
`else
    // Keeps TO_CYC referenced in builds without the watchdog
    logic [TO_W-1:0] unused_idle_cnt;
    assign unused_idle_cnt = '0;
    assign to_hit          = 1'b0;
    assign timeout         = 1'b0;
`endif

endmodule

// File: tb/tb_gate_response_checker.sv
// Randomized self-checking bench for gate_response_checker against a spec-level model.
module tb_gate_response_checker;
    import gate_chk_pkg::*;

    localparam int unsigned N_IN   = 2;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned TO_CYC = 8;
    localparam int          CMAX   = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] truth_tbl = 4'd0;
    logic       in_valid = 1'b0;
    logic [1:0] in_vec = 2'd0;
    logic       dut_y = 1'b0;

    logic       busy, done, all_pass, first_fail_vld, timeout;
    logic [7:0] pass_cnt, fail_cnt;
    logic [1:0] first_fail_vec;
    logic [3:0] cov_map;

    int errors = 0;
    int checks = 0;

    gate_response_checker #(.N_IN(N_IN), .CNT_W(CNT_W), .TO_CYC(TO_CYC)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .truth_tbl      (truth_tbl),
        .in_valid       (in_valid),
        .in_vec         (in_vec),
        .dut_y          (dut_y),
        .busy           (busy),
        .done           (done),
        .all_pass       (all_pass),
        .pass_cnt       (pass_cnt),
        .fail_cnt       (fail_cnt),
        .first_fail_vld (first_fail_vld),
        .first_fail_vec (first_fail_vec),
        .cov_map        (cov_map),
        .timeout        (timeout)
    );

    always #5 clk = ~clk;

    // Reference model: session state described by the checker's rules
    logic       m_run, m_done, m_to, m_ffv;
    logic [1:0] m_ffvec;
    logic [3:0] m_tbl, m_cov;
    int         m_pass, m_fail, m_idle;

    logic [26:0] dut_obs;
    assign dut_obs = {busy, done, all_pass, pass_cnt, fail_cnt,
                      first_fail_vld, first_fail_vec, cov_map, timeout};

    function automatic logic [26:0] model_obs();
        logic ap;
        ap = m_done && (m_fail == 0) && !m_to;
        return {m_run, m_done, ap, 8'(m_pass), 8'(m_fail), m_ffv, m_ffvec, m_cov, m_to};
    endfunction

    task automatic model_clear();
        m_run = 1'b0; m_done = 1'b0; m_to = 1'b0; m_ffv = 1'b0; m_ffvec = 2'd0;
        m_tbl = 4'd0; m_cov = 4'd0; m_pass = 0; m_fail = 0; m_idle = 0;
    endtask

    // Apply one cycle of inputs, advance the model by one clock edge
    task automatic step(input logic r, input logic s, input logic [3:0] tt,
                        input logic v, input logic [1:0] vec, input logic y);
        rst = r; start = s; truth_tbl = tt; in_valid = v; in_vec = vec; dut_y = y;
        @(posedge clk);
        if (r) begin
            model_clear();
        end else if (s) begin
            model_clear();
            m_tbl = tt;
            m_run = 1'b1;
        end else if (m_run && v) begin
            if (y == m_tbl[vec]) m_pass = (m_pass < CMAX) ? m_pass + 1 : CMAX;
            else begin
                m_fail = (m_fail < CMAX) ? m_fail + 1 : CMAX;
                if (!m_ffv) begin m_ffv = 1'b1; m_ffvec = vec; end
            end
            m_cov[vec] = 1'b1;
            m_idle = 0;
            if (m_cov == 4'hF) begin m_run = 1'b0; m_done = 1'b1; end
        end
`ifdef GATE_CHK_TIMEOUT_EN
        else if (m_run) begin
            if (m_idle == TO_CYC - 1) begin m_run = 1'b0; m_done = 1'b1; m_to = 1'b1; end
            else m_idle++;
        end
`endif
        #1;
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_reset();
        step(1, 0, 4'd0, 0, 2'd0, 0);
        step(1, 1, TT_OR, 1, 2'd3, 1);
        checks++;
        if (dut_obs !== 27'd0) begin
            errors++; $display("FAIL reset: got %h need %h", dut_obs, 27'd0);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 4'($urandom), 1, 2'(i), 1'($urandom));
        checks++;
        if (dut_obs !== model_obs() || dut_obs !== 27'd0) begin
            errors++; $display("FAIL idle_ignore: got %h need %h", dut_obs, model_obs());
        end
    endtask

    task automatic test_or_pass();
        logic [3:0] tt;
        tt = TT_OR;
        step(0, 1, TT_OR, 0, 2'd0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 4'($urandom), 1, 2'(i), tt[i]);
            checks++;
            if (dut_obs !== model_obs()) begin
                errors++; $display("FAIL or_pass[%0d]: got %h need %h", i, dut_obs, model_obs());
            end
        end
        checks++;
        if (done !== 1'b1 || pass_cnt !== 8'd4 || fail_cnt !== 8'd0 ||
            cov_map !== 4'hF || all_pass !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL or_final: done=%b pass=%0d fail=%0d cov=%b ap=%b need 1 4 0 1111 1",
                     done, pass_cnt, fail_cnt, cov_map, all_pass);
        end
    endtask

    task automatic test_fault();
        logic [1:0] vecs [4];
        logic       ys   [4];
        vecs = '{2'd0, 2'd1, 2'd3, 2'd2};
        ys   = '{1'b0, 1'b1, 1'b0, 1'b0};
        step(0, 1, TT_OR, 0, 2'd0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, TT_AND, 1, vecs[i], ys[i]);
        checks++;
        if (dut_obs !== model_obs() || fail_cnt !== 8'd2 || pass_cnt !== 8'd2 ||
            first_fail_vec !== 2'b11 || first_fail_vld !== 1'b1 || all_pass !== 1'b0 ||
            done !== 1'b1) begin
            errors++;
            $display("FAIL fault: got %h need %h (fail=2 pass=2 ffvec=11)", dut_obs, model_obs());
        end
    endtask

    task automatic test_dup_ignore();
        logic [3:0] tt;
        logic [1:0] vecs [5];
        tt = TT_XNOR;
        vecs = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
        step(0, 1, TT_XNOR, 0, 2'd0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 4'($urandom), 1, vecs[i], tt[vecs[i]]);
            if (i == 3) begin
                checks++;
                if (done !== 1'b0 || busy !== 1'b1 || pass_cnt !== 8'd4) begin
                    errors++; $display("FAIL dup_early_done: done=%b busy=%b pass=%0d need 0 1 4",
                                       done, busy, pass_cnt);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || pass_cnt !== 8'd5 || cov_map !== 4'hF) begin
            errors++; $display("FAIL dup_final: done=%b pass=%0d cov=%b need 1 5 1111",
                               done, pass_cnt, cov_map);
        end
        for (int i = 0; i < 4; i++) step(0, 0, tt, 1, 2'(i), ~tt[i]);
        checks++;
        if (dut_obs !== model_obs() || pass_cnt !== 8'd5 || fail_cnt !== 8'd0) begin
            errors++; $display("FAIL done_ignore: got %h need %h", dut_obs, model_obs());
        end
    endtask

    task automatic test_saturation();
        step(0, 1, TT_AND, 0, 2'd0, 0);
        step(0, 1, TT_AND, 1, 2'd3, 1);
        checks++;
        if (dut_obs !== model_obs() || pass_cnt !== 8'd0 || cov_map !== 4'd0) begin
            errors++; $display("FAIL start_sample_ignored: got %h need %h", dut_obs, model_obs());
        end
        for (int i = 0; i < 300; i++) step(0, 0, TT_OR, 1, 2'd0, 0);
        checks++;
        if (dut_obs !== model_obs() || pass_cnt !== 8'd255 || cov_map !== 4'b0001 || busy !== 1'b1) begin
            errors++; $display("FAIL pass_sat: pass=%0d cov=%b busy=%b need 255 0001 1",
                               pass_cnt, cov_map, busy);
        end
        for (int i = 0; i < 300; i++) step(0, 0, TT_OR, 1, 2'd0, 1);
        checks++;
        if (dut_obs !== model_obs() || fail_cnt !== 8'd255 || pass_cnt !== 8'd255 ||
            first_fail_vec !== 2'd0 || first_fail_vld !== 1'b1) begin
            errors++; $display("FAIL fail_sat: got %h need %h", dut_obs, model_obs());
        end
    endtask

    task automatic test_rst_restart();
        logic [3:0] tt;
        step(0, 1, TT_OR, 0, 2'd0, 0);
        step(0, 0, TT_OR, 1, 2'd0, 1);
        step(0, 0, TT_OR, 1, 2'd1, 1);
        step(1, 1, TT_OR, 1, 2'd2, 1);
        checks++;
        if (dut_obs !== 27'd0 || dut_obs !== model_obs()) begin
            errors++; $display("FAIL rst_mid_run: got %h need %h", dut_obs, 27'd0);
        end
        tt = TT_OR;
        step(0, 1, TT_OR, 0, 2'd0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, TT_OR, 1, 2'(i), tt[i]);
        step(0, 1, TT_XOR, 0, 2'd0, 0);
        checks++;
        if (dut_obs !== model_obs() || busy !== 1'b1 || pass_cnt !== 8'd0 || cov_map !== 4'd0) begin
            errors++; $display("FAIL restart_clear: got %h need %h", dut_obs, model_obs());
        end
        tt = TT_XOR;
        for (int i = 3; i >= 0; i--) step(0, 0, TT_OR, 1, 2'(i), tt[i]);
        checks++;
        if (dut_obs !== model_obs() || all_pass !== 1'b1 || pass_cnt !== 8'd4) begin
            errors++; $display("FAIL restart_xor: got %h need %h", dut_obs, model_obs());
        end
    endtask

    task automatic test_watchdog();
        logic [3:0] tt;
        tt = TT_OR;
        step(0, 1, TT_OR, 0, 2'd0, 0);
        step(0, 0, TT_OR, 1, 2'd0, tt[0]);
        step(0, 0, TT_OR, 1, 2'd1, tt[1]);
        for (int i = 0; i < 7; i++) step(0, 0, TT_OR, 0, 2'd0, 0);
        checks++;
        if (dut_obs !== model_obs() || busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL watchdog_early: got %h need %h", dut_obs, model_obs());
        end
        step(0, 0, TT_OR, 0, 2'd0, 0);
`ifdef GATE_CHK_TIMEOUT_EN
        checks++;
        if (dut_obs !== model_obs() || done !== 1'b1 || timeout !== 1'b1 ||
            cov_map !== 4'b0011 || all_pass !== 1'b0) begin
            errors++; $display("FAIL watchdog_fire: got %h need %h", dut_obs, model_obs());
        end
`else
        for (int i = 0; i < 40; i++) step(0, 0, TT_OR, 0, 2'd0, 0);
        checks++;
        if (dut_obs !== model_obs() || busy !== 1'b1 || timeout !== 1'b0) begin
            errors++; $display("FAIL no_watchdog: got %h need %h", dut_obs, model_obs());
        end
`endif
    endtask

    task automatic test_random();
        logic [1:0] v;
        for (int i = 0; i < 3000; i++) begin
            v = 2'($urandom);
            step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 39) == 0),
                 4'($urandom), 1'($urandom_range(0, 3) != 0), v,
                 ($urandom_range(0, 7) == 0) ? ~m_tbl[v] : m_tbl[v]);
            checks++;
            if (dut_obs !== model_obs()) begin
                errors++; $display("FAIL random[%0d]: got %h need %h", i, dut_obs, model_obs());
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_or_pass();
        test_fault();
        test_dup_ignore();
        test_saturation();
        test_rst_restart();
        test_watchdog();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gate_response_checker.md
Name: gate_response_checker

Overview:
- Self-checking response end for the basic-logic-gate stimulus benches. The bench drives input vectors into a gate under test; this block takes each applied vector and the gate's output, and compares them against a programmable truth table.
- Accumulates pass/fail counts, records the first failing vector, and tracks input-space coverage. Declares done once every input combination has been seen.
- Synthesizable, so the same checker serves simulation and on-board gate tests.

Parameters:
- N_IN, 2, number of gate inputs; truth table has 2**N_IN entries
- CNT_W, 8, width of pass/fail counters
- TO_CYC, 64, idle-timeout cycles; used only with GATE_CHK_TIMEOUT_EN

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse: latch truth_tbl, clear stats, enter RUN
- truth_tbl  in  2**N_IN  expected output; bit i is the output for in_vec==i
- in_valid  in  1  in_vec/dut_y qualify this cycle
- in_vec  in  N_IN  input vector applied to the gate
- dut_y  in  1  observed gate output
- busy  out  1  high in RUN
- done  out  1  high in DONE
- all_pass  out  1  done && fail_cnt==0
- pass_cnt  out  CNT_W  matching samples, saturating
- fail_cnt  out  CNT_W  mismatching samples, saturating
- first_fail_vld  out  1  a mismatch has been recorded
- first_fail_vec  out  N_IN  in_vec of the first mismatch
- cov_map  out  2**N_IN  bit i set once in_vec==i has been checked
- timeout  out  1  RUN ended by watchdog (0 without macro)

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; all outputs 0; latched table 0.
- FSM IDLE, RUN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE on the edge where cov_map becomes all-ones.
  - DONE -> RUN on start.
  - RUN with start: restart, same as from IDLE.
- start effects, next cycle:
  - truth_tbl is latched into tbl_q.
  - pass_cnt, fail_cnt, cov_map, first_fail_* and timeout are cleared.
  - Any in_valid in the start cycle is ignored.
- RUN sample, when in_valid=1:
  - exp = tbl_q[in_vec]; match = (dut_y == exp).
  - Registered update visible one cycle later: pass_cnt or fail_cnt +1, and cov_map[in_vec] set.
- First mismatch: first_fail_vec <= in_vec and first_fail_vld <= 1. Later mismatches do not overwrite it.
- Counters saturate at 2**CNT_W-1 and never wrap.
- Repeated vectors are counted each time; coverage is unchanged.
- The final covering sample is counted in the same edge that enters DONE. done and the final counts appear together.
- in_valid in IDLE or DONE is ignored; all stats hold.
- truth_tbl changes after start have no effect until the next start.
- rst mid-RUN aborts immediately to IDLE with everything cleared; rst has priority over start.
- all_pass is combinational from done and fail_cnt.

Optional Feature:
- Macro GATE_CHK_TIMEOUT_EN.
- Defined:
  - An idle counter runs in RUN; it clears on in_valid or start.
  - When it reaches TO_CYC-1 without a sample: state -> DONE and timeout <= 1. cov_map stays partial and stats hold.
  - all_pass then remains 0, because all_pass additionally requires !timeout.
- Not defined: no counter; timeout is tied 0; RUN waits indefinitely.

Decomposition:
- Package gate_chk_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - 2-input table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111, TT_NOR=4'b0001, TT_XNOR=4'b1001
- One sub-module, sat_counter (parameter W; ports clr, inc, q), instantiated for pass and fail, reused for the timeout counter.

Test Plan:
- OR pass: start with truth_tbl=TT_OR; drive (00,0),(01,1),(10,1),(11,1) on consecutive cycles.
  -> cycle after 4th: done=1, pass_cnt=4, fail_cnt=0, cov_map=4'b1111, all_pass=1.
- Fault: same stimulus but (11,0) then (10,0).
  -> fail_cnt=2, pass_cnt=2, first_fail_vec=2'b11, first_fail_vld=1, all_pass=0.
- Duplicates and ignore: drive 00,00,01,10,11 correctly.
  -> pass_cnt=5; done only after 11.
  -> in_valid during IDLE and after done leaves counts unchanged.
- Saturation, CNT_W=2: 5 correct samples of 00 with TT_AND.
  -> pass_cnt=3 (held), cov_map=4'b0001, busy=1.
- Reset and restart:
  - rst mid-RUN after 2 samples -> all outputs 0 next cycle, state IDLE.
  - start in DONE with TT_XOR -> stats cleared, new table used.
- Timeout (macro on, TO_CYC=8): start, drive 00 and 01 correctly, then idle.
  -> 8 cycles later done=1, timeout=1, cov_map=4'b0011, all_pass=0.
